// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: IF fetch state encoding, the NOP bubble word
// and the reset PC default.
package pipeline_pkg;

    typedef enum logic [1:0] {
        FETCH_REQ  = 2'd0,  // presenting a request at pc
        FETCH_WAIT = 2'd1,  // request accepted, awaiting read data
        FETCH_HOLD = 2'd2   // fetched word held for IF/ID
    } fetch_state_e;

    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

    // Redirect targets are word aligned; low two bits are discarded.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_unit.sv
// IF-stage producer for the IF/ID register. Owns the PC, keeps at most one
// instruction-memory request outstanding, holds the fetched word across
// stalls and drops wrong-path words after a redirect.
//
// Ports
//   clk, reset            clock; synchronous active-high reset
//   stall                 IF/ID stall: hold the current fetched word
//   redirect_valid/target taken branch/jump; new PC (low 2 bits forced to 0)
//   imem_req/addr         request valid / address (= pc)
//   imem_ready            request accepted when imem_req=1
//   imem_rvalid/rdata     returned instruction word
//   IF_inst               fetched word, NOP_INST when !IF_valid
//   IF_PC_plus_4          pc+4 of IF_inst, 0 when !IF_valid
//   IF_valid              IF_inst is a real fetched instruction
module if_fetch_unit
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_inst,
    output logic [31:0] IF_PC_plus_4,
    output logic        IF_valid
);

    fetch_state_e state;
    logic [31:0]  pc;
    logic [31:0]  inst_buf;
    logic         discard;   // outstanding request belongs to a dropped path
    logic         if_valid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FETCH_REQ;
            pc         <= RESET_PC;
            inst_buf   <= '0;
            discard    <= 1'b0;
            if_valid_q <= 1'b0;
        end else if (redirect_valid) begin
            pc         <= align_word(redirect_target);
            if_valid_q <= 1'b0;
            case (state)
                FETCH_REQ: begin
                    // An accepted request is now wrong-path; its data must be eaten.
                    if (imem_ready) begin
                        state   <= FETCH_WAIT;
                        discard <= 1'b1;
                    end
                end
                FETCH_WAIT: begin
                    // Data arriving this cycle is the old-path word: drop it,
                    // nothing remains outstanding.
                    if (imem_rvalid) begin
                        state   <= FETCH_REQ;
                        discard <= 1'b0;
                    end else begin
                        discard <= 1'b1;
                    end
                end
                default: state <= FETCH_REQ;
            endcase
        end else begin
            case (state)
                FETCH_REQ: begin
                    if (imem_ready) state <= FETCH_WAIT;
                end
                FETCH_WAIT: begin
                    if (imem_rvalid) begin
                        if (discard) begin
                            discard <= 1'b0;
                            state   <= FETCH_REQ;
                        end else begin
                            inst_buf   <= imem_rdata;
                            if_valid_q <= 1'b1;
                            state      <= FETCH_HOLD;
                        end
                    end
                end
                FETCH_HOLD: begin
                    // IF/ID captures the word in the same cycle we advance.
                    if (!stall) begin
                        pc         <= pc + 32'd4;
                        if_valid_q <= 1'b0;
                        state      <= FETCH_REQ;
                    end
                end
                default: state <= FETCH_REQ;
            endcase
        end
    end

    assign imem_req     = (state == FETCH_REQ) && !reset;
    assign imem_addr    = pc;
    assign IF_valid     = if_valid_q;
    assign IF_inst      = if_valid_q ? inst_buf : NOP_INST;
    assign IF_PC_plus_4 = if_valid_q ? (pc + 32'd4) : 32'd0;

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] IF_inst;
    logic [31:0] IF_PC_plus_4;
    logic        IF_valid;

    int checks   = 0;
    int failures = 0;

    if_fetch_unit dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .IF_inst         (IF_inst),
        .IF_PC_plus_4    (IF_PC_plus_4),
        .IF_valid        (IF_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Zero-wait fetch from REQ: accept this cycle, data next cycle; ends in HOLD.
    task automatic fetch(input logic [31:0] word);
        imem_ready = 1'b1;
        tick();
        imem_ready  = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = word;
        tick();
        imem_rvalid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        tick(); tick();
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, IF_valid}, 32'd0);
        chk("rst_inst", IF_inst, 32'h0000_0000);
        chk("rst_pcp4", IF_PC_plus_4, 32'd0);
        reset = 1'b0;
        #1;
        chk("t1_req", {31'd0, imem_req}, 32'd1);
        chk("t1_addr", imem_addr, 32'h0000_3000);

        // 1: basic zero-wait fetch
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        chk("t1_wait_req", {31'd0, imem_req}, 32'd0);
        imem_rvalid = 1'b1; imem_rdata = 32'h2008_0005;
        tick();
        imem_rvalid = 1'b0;
        chk("t1_valid", {31'd0, IF_valid}, 32'd1);
        chk("t1_inst", IF_inst, 32'h2008_0005);
        chk("t1_pcp4", IF_PC_plus_4, 32'h0000_3004);
        tick();
        chk("t1_next_addr", imem_addr, 32'h0000_3004);
        chk("t1_next_req", {31'd0, imem_req}, 32'd1);
        chk("t1_next_valid", {31'd0, IF_valid}, 32'd0);

        // 2: stall in HOLD
        fetch(32'h1234_5678);
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_inst", IF_inst, 32'h1234_5678);
            chk("t2_pcp4", IF_PC_plus_4, 32'h0000_3008);
            chk("t2_req", {31'd0, imem_req}, 32'd0);
        end
        stall = 1'b0;
        tick();
        chk("t2_addr", imem_addr, 32'h0000_3008);
        chk("t2_req_after", {31'd0, imem_req}, 32'd1);

        // 3: redirect in WAIT, stale data arrives two cycles later
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        redirect_valid = 1'b1; redirect_target = 32'h0000_4000;
        tick();
        redirect_valid = 1'b0;
        chk("t3_valid0", {31'd0, IF_valid}, 32'd0);
        chk("t3_req0", {31'd0, imem_req}, 32'd0);
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        chk("t3_valid", {31'd0, IF_valid}, 32'd0);
        chk("t3_inst", IF_inst, 32'h0000_0000);
        chk("t3_addr", imem_addr, 32'h0000_4000);
        chk("t3_req", {31'd0, imem_req}, 32'd1);

        // 4: redirect coincident with rvalid in WAIT
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111;
        redirect_valid = 1'b1; redirect_target = 32'h0000_5002;
        tick();
        imem_rvalid = 1'b0; redirect_valid = 1'b0;
        chk("t4_addr", imem_addr, 32'h0000_5000);
        chk("t4_req", {31'd0, imem_req}, 32'd1);
        chk("t4_valid0", {31'd0, IF_valid}, 32'd0);
        fetch(32'h2222_2222);
        chk("t4_valid", {31'd0, IF_valid}, 32'd1);
        chk("t4_inst", IF_inst, 32'h2222_2222);
        chk("t4_pcp4", IF_PC_plus_4, 32'h0000_5004);

        // 5: redirect beats stall in HOLD
        stall = 1'b1;
        redirect_valid = 1'b1; redirect_target = 32'h0000_6000;
        tick();
        redirect_valid = 1'b0; stall = 1'b0;
        chk("t5_valid", {31'd0, IF_valid}, 32'd0);
        chk("t5_addr", imem_addr, 32'h0000_6000);
        chk("t5_req", {31'd0, imem_req}, 32'd1);

        // 6: reset in WAIT, stray rvalid, then PC wrap
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        reset = 1'b1;
        #1;
        chk("t6_req_in_rst", {31'd0, imem_req}, 32'd0);
        tick();
        reset = 1'b0;
        #1;
        chk("t6_addr_rst", imem_addr, 32'h0000_3000);
        imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        tick();
        imem_rvalid = 1'b0;
        chk("t6_stray_valid", {31'd0, IF_valid}, 32'd0);
        chk("t6_stray_addr", imem_addr, 32'h0000_3000);
        chk("t6_stray_req", {31'd0, imem_req}, 32'd1);
        redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFF;
        tick();
        redirect_valid = 1'b0;
        chk("t6_wrap_addr", imem_addr, 32'hFFFF_FFFC);
        fetch(32'h3333_3333);
        chk("t6_wrap_valid", {31'd0, IF_valid}, 32'd1);
        chk("t6_wrap_inst", IF_inst, 32'h3333_3333);
        chk("t6_wrap_pcp4", IF_PC_plus_4, 32'h0000_0000);
        tick();
        chk("t6_wrap_next", imem_addr, 32'h0000_0000);
        chk("t6_wrap_req", {31'd0, imem_req}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
